// File: rtl/dec_pkg.sv
// dec_pkg: shared types, constants and one-hot helper for dec_nto1h_seq.
// Contents: state_e (ST_IDLE/ST_DIRECT/ST_SCAN), MODE_DIRECT/MODE_SCAN,
// MAX_N/MAX_W (largest supported code/output width), dec_onehot().
package dec_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_e;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
    localparam int   MAX_N       = 8;
    localparam int   MAX_W       = 1 << MAX_N;
    function automatic logic [MAX_W-1:0] dec_onehot(input int unsigned i);
        return MAX_W'(1) << i;
    endfunction
endpackage

// File: rtl/dec_scan_ctr.sv
// dec_scan_ctr: scan divider and index counter for dec_nto1h_seq.
// Ports: clk, rst_n (async active-low); clr_i clears divider/index/wrap;
// run_i lets the divider count; free_i marks a free output slot;
// step_o fires when the current index is to be loaded; idx_o current index;
// wrap_o one-cycle pulse after the last index (2^N-1) has been stepped.
module dec_scan_ctr #(
    parameter int N        = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         run_i,
    input  logic         free_i,
    output logic         step_o,
    output logic [N-1:0] idx_o,
    output logic         wrap_o
);
    localparam int DW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] TERM = DW'(SCAN_DIV - 1);
    logic [DW-1:0] div_q, div_d;
    logic [N-1:0]  idx_q, idx_d;
    logic          wrap_q, wrap_d, term;
    assign term   = div_q == TERM;
    assign step_o = run_i & term & free_i & !clr_i;
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;
    // A stalled terminal count simply holds: neither branch below fires.
    always_comb begin
        div_d  = div_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        if (clr_i) begin
            div_d = '0;
            idx_d = '0;
        end else if (step_o) begin
            div_d  = '0;
            idx_d  = idx_q + 1'b1;
            wrap_d = &idx_q;
        end else if (run_i && !term) begin
            div_d = div_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            idx_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
        end
    end
endmodule

// File: rtl/dec_nto1h_seq.sv
// dec_nto1h_seq: registered N-to-2^N one-hot decoder with valid/ready flow
// control and optional auto-scan (built only when DEC_NTO1H_SCAN_EN is defined).
// Ports: clk, rst_n (async active-low); en_i, mode_i (0 direct, 1 scan);
// in_valid_i/in_ready_o/code_i input side; out_valid_o/out_ready_i/onehot_o/
// idx_o output side; scan_wrap_o pulse when the scan index rolls over.
module dec_nto1h_seq
    import dec_pkg::*;
#(
    parameter int N        = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              mode_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [N-1:0]      code_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [(1<<N)-1:0] onehot_o,
    output logic [N-1:0]      idx_o,
    output logic              scan_wrap_o
);
    localparam int W = 1 << N;
    state_e         state_q, state_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   onehot_q, onehot_d;
    logic [N-1:0]   idx_q, idx_d, sel_idx, scan_idx;
    logic           slot_free, change, accept, scan_step;
    assign slot_free  = !out_valid_q | out_ready_i;
    assign in_ready_o = (state_q == ST_DIRECT) & slot_free;
    assign accept     = in_valid_i & in_ready_o;
    assign change     = state_d != state_q;
    assign sel_idx    = accept ? code_i : scan_idx;
`ifdef DEC_NTO1H_SCAN_EN
    dec_scan_ctr #(.N(N), .SCAN_DIV(SCAN_DIV)) u_scan (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (change),
        .run_i  (state_q == ST_SCAN),
        .free_i (slot_free),
        .step_o (scan_step),
        .idx_o  (scan_idx),
        .wrap_o (scan_wrap_o)
    );
`else
    localparam int unused_scan_div = SCAN_DIV;
    logic unused_mode;
    assign unused_mode = mode_i;
    assign scan_step   = 1'b0;
    assign scan_idx    = '0;
    assign scan_wrap_o = 1'b0;
`endif
    always_comb begin
        state_d = en_i ? ST_DIRECT : ST_IDLE;
`ifdef DEC_NTO1H_SCAN_EN
        if (en_i && mode_i == MODE_SCAN) state_d = ST_SCAN;
`endif
    end
    // A state change wins over everything and drops any held word silently.
    always_comb begin
        out_valid_d = out_valid_q;
        onehot_d    = onehot_q;
        idx_d       = idx_q;
        if (change) begin
            out_valid_d = 1'b0;
            onehot_d    = '0;
            idx_d       = '0;
        end else if (accept || scan_step) begin
            out_valid_d = 1'b1;
            onehot_d    = W'(dec_onehot(int'(sel_idx)));
            idx_d       = sel_idx;
        end else if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
            onehot_d    = '0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            onehot_q    <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            onehot_q    <= onehot_d;
            idx_q       <= idx_d;
        end
    end
    assign out_valid_o = out_valid_q;
    assign onehot_o    = onehot_q;
    assign idx_o       = idx_q;
endmodule

// File: tb/tb_dec_nto1h_seq.sv
// tb_dec_nto1h_seq: directed + random self-checking bench for dec_nto1h_seq
// (N=3, SCAN_DIV=3); scan checks are active when DEC_NTO1H_SCAN_EN is defined.
module tb_dec_nto1h_seq;
    localparam int N = 3;
    localparam int W = 8;
    localparam int SCAN_DIV = 3;
`ifdef DEC_NTO1H_SCAN_EN
    localparam bit SCAN_EN = 1'b1;
`else
    localparam bit SCAN_EN = 1'b0;
`endif
    logic clk = 1'b0, rst_n = 1'b0;
    logic en = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [N-1:0] code = '0;
    logic in_ready, out_valid, scan_wrap;
    logic [W-1:0] onehot;
    logic [N-1:0] idx;
    int total = 0, bad = 0;
    // reference: 0 idle, 1 direct, 2 scan; cycles waited; next scan index
    int m_st = 0, m_valid = 0, m_idx = 0, m_cnt = 0, m_nxt = 0, m_wrap = 0;

    dec_nto1h_seq #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .mode_i      (mode),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .code_i      (code),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .onehot_o    (onehot),
        .idx_o       (idx),
        .scan_wrap_o (scan_wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("onehot", 32'(onehot), m_valid != 0 ? 32'(1) << m_idx : 32'(0));
        chk("idx", 32'(idx), 32'(m_idx));
        chk("scan_wrap", 32'(scan_wrap), 32'(m_wrap));
    endtask

    task automatic model_reset();
        m_st = 0; m_valid = 0; m_idx = 0; m_cnt = 0; m_nxt = 0; m_wrap = 0;
    endtask

    task automatic model();
        int want;
        bit free;
        want = !en ? 0 : (SCAN_EN && mode) ? 2 : 1;
        free = (m_valid == 0) || out_ready;
        if (want != m_st) begin
            model_reset();
            m_st = want;
            return;
        end
        m_wrap = 0;
        if (m_valid != 0 && out_ready) m_valid = 0;
        if (m_st == 1 && in_valid && free) begin
            m_valid = 1;
            m_idx = int'(code);
        end
        if (m_st == 2) begin
            if (m_cnt < SCAN_DIV - 1) m_cnt++;
            else if (free) begin
                m_valid = 1;
                m_idx = m_nxt;
                m_wrap = (m_nxt == W - 1) ? 1 : 0;
                m_nxt = (m_nxt + 1) % W;
                m_cnt = 0;
            end
        end
    endtask

    task automatic step();
        #1;
        chk("in_ready", 32'(in_ready), 32'(m_st == 1 && (m_valid == 0 || out_ready)));
        model();
        @(posedge clk);
        #1;
        chk_outs();
    endtask

    task automatic drv(input bit e, input bit m, input bit iv, input logic [N-1:0] c, input bit ordy);
        en = e; mode = m; in_valid = iv; code = c; out_ready = ordy;
        step();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_outs();
        chk("in_ready_rst", 32'(in_ready), 32'(0));
        rst_n = 1'b1;
        repeat (3) drv(0, 0, 1, 3, 1);
        drv(1, 0, 0, 0, 1);
        for (int c = 0; c < W; c++) drv(1, 0, 1, N'(c), 1);
        drv(1, 0, 0, 0, 1);
        drv(1, 0, 1, 5, 0);
        repeat (3) drv(1, 0, 0, 0, 0);
        drv(1, 0, 1, 2, 0);
        drv(1, 0, 1, 2, 1);
        drv(1, 0, 0, 0, 1);
        repeat (30) drv(1, 1, 1'($urandom), N'($urandom), 1);
        repeat (5) drv(1, 1, 0, 0, 0);
        repeat (12) drv(1, 1, 0, 0, 1);
        drv(1, 0, 0, 0, 1);
        drv(1, 0, 1, 6, 0);
        drv(1, 1, 0, 0, 0);
        repeat (4) drv(1, 1, 0, 0, 1);
        drv(0, 1, 0, 0, 1);
        drv(1, 0, 0, 0, 1);
        drv(1, 0, 1, 4, 0);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk_outs();
        chk("in_ready_async", 32'(in_ready), 32'(0));
        @(posedge clk);
        #1;
        chk_outs();
        rst_n = 1'b1;
        en = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            drv(en, mode, 1'($urandom), N'($urandom), $urandom_range(0, 3) != 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
